lut_cfg_loader: RTL and testbench
=================================

LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_LUTS, default 4, number of frac_lut4 instances on the configuration chain.
REQ-002 SHALL have parameter WORD_W, default 17, bits per LUT (16 truth-table SRAM + 1 mode).
REQ-003 SHALL have port prog_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a load sequence.
REQ-006 SHALL have port abort, input, 1, terminate the sequence in progress.
REQ-007 SHALL have port cfg_valid, input, 1, cfg_data holds a valid word.
REQ-008 SHALL have port cfg_data, input, WORD_W; bit 16 = mode, bits 15..0 = sram[15..0].
REQ-009 SHALL have port cfg_ready, output, 1, loader accepts a word this cycle.
REQ-010 SHALL have port ccff_head, output, 1, serial data into the chain head.
REQ-011 SHALL have port shift_en, output, 1, chain shift enable.
REQ-012 SHALL have port ccff_tail, input, 1, serial data from the chain tail.
REQ-013 SHALL have port rd_data, output, WORD_W, word displaced from the chain.
REQ-014 SHALL have port rd_valid, output, 1, rd_data valid; one-cycle pulse.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE.
REQ-018 IDLE: start=1 SHALL move the FSM to LOAD and clear the LUT counter to 0; start SHALL be ignored in every other state.
REQ-019 LOAD: cfg_ready SHALL be 1 and all other strobes 0; the handshake cfg_valid&cfg_ready SHALL load cfg_data into the shift register and move the FSM to SHIFT.
REQ-020 LOAD: when cfg_valid=0 the FSM SHALL remain in LOAD indefinitely, with no timeout.
REQ-021 SHIFT: shift_en SHALL be 1 for exactly WORD_W consecutive cycles.
REQ-022 SHIFT: ccff_head SHALL equal shift-register bit 0, so cfg_data[0] is shifted first and cfg_data[WORD_W-1] last.
REQ-023 SHIFT: the shift register SHALL shift right each cycle.
REQ-024 SHIFT: each cycle, ccff_tail SHALL be sampled into the readback register MSB with that register shifting right, so rd_data bit order matches cfg_data.
REQ-025 After the WORD_W-th shift cycle, rd_valid SHALL pulse for 1 cycle carrying the completed readback word.
REQ-026 At the end of a word the LUT counter SHALL increment; when the counter was NUM_LUTS-1 the FSM SHALL go to DONE, otherwise to LOAD.
REQ-027 Words SHALL be supplied farthest-LUT first; after NUM_LUTS words, LUT k holds the k-th word from the end.
REQ-028 DONE: done=1 for 1 cycle, then the FSM SHALL return to IDLE.
REQ-029 The first NUM_LUTS rd_valid words SHALL be the previous chain contents, last LUT first.
REQ-030 Throughput SHALL be 1 LUT per WORD_W+1 cycles with cfg_valid held high; with WORD_W=17 and NUM_LUTS=4, done SHALL assert 72 cycles after the start cycle.
REQ-031 abort=1 in any state SHALL return the FSM to IDLE next cycle, with shift_en=0 and no done or rd_valid pulse; a partially shifted chain is left as-is.
REQ-032 abort and start asserted together in IDLE: abort SHALL win.
REQ-033 The LUT counter width SHALL be clog2(NUM_LUTS), minimum 1; NUM_LUTS=1 SHALL be legal.

Reset
REQ-034 reset=1 SHALL force IDLE on the next prog_clk edge.
REQ-035 While reset=1, every output SHALL be 0: cfg_ready, shift_en, ccff_head, rd_valid, busy, done and rd_data.
REQ-036 reset SHALL clear the shift register, readback register and counters; reset mid-SHIFT SHALL stop shifting immediately.

Structure
REQ-037 The state encoding enum and the WORD_W default SHALL live in shared package lut_cfg_pkg.
REQ-038 One sub-module, lut_cfg_shifter, SHALL hold the parallel-load shift register, readback register and bit counter; the FSM and LUT counter SHALL stay in the top module.

Verification
REQ-039 Reset, then start with cfg_valid held and 4 words 0x1_8000, 0x0_00FF, 0x1_AAAA, 0x0_0001 into a 68-bit behavioural chain -> chain holds those words with the first word farthest from the head, done is high at cycle 72, and busy falls the following cycle.
REQ-040 Preload the chain with 4 known words and reload it -> the 4 rd_valid words equal the preload, last LUT first.
REQ-041 Hold cfg_valid low for 10 cycles in LOAD -> shift_en stays 0, cfg_ready stays 1, and shifting resumes 1 cycle after valid.
REQ-042 Assert abort at SHIFT bit 8 of word 2 -> IDLE next cycle, no done, and 25 total shift_en cycles observed.
REQ-043 Assert reset mid-SHIFT, then start -> all outputs 0 during reset, and a clean 4-word load follows.
REQ-044 Assert start while busy, and start with abort in IDLE -> both ignored, with no state change.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the LUT configuration loader: FSM state encoding,
// default word width and a counter-width helper.
package lut_cfg_pkg;

  localparam int LUT_WORD_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } lut_state_e;

  // Counters never collapse to zero width, so a single-entry range still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Datapath for one configuration word: parallel-load shift register feeding the
// chain head, readback register capturing the chain tail, and the bit counter.
module lut_cfg_shifter
  import lut_cfg_pkg::*;
#(
  parameter int WORD_W = LUT_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              clear,
  input  logic              ser_in,
  output logic              ser_out,
  output logic [WORD_W-1:0] par_out,
  output logic              last_bit
);

  localparam int BIT_W = cnt_width(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg_r;
  logic [WORD_W-1:0] rb_r;
  logic [BIT_W-1:0]  bit_cnt_r;

  // Shift register drains LSB first and zero-fills, so it reads zero once a word is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_r    <= {WORD_W{1'b0}};
      rb_r      <= {WORD_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
    end else begin
      if (clear) begin
        sreg_r <= {WORD_W{1'b0}};
      end else if (load) begin
        sreg_r <= load_data;
      end else if (shift) begin
        sreg_r <= {1'b0, sreg_r[WORD_W-1:1]};
      end else begin
        sreg_r <= sreg_r;
      end

      if (load || clear) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (shift) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      if (shift) begin
        rb_r <= {ser_in, rb_r[WORD_W-1:1]};
      end else begin
        rb_r <= rb_r;
      end
    end
  end

  assign ser_out  = sreg_r[0];
  assign par_out  = rb_r;
  assign last_bit = (bit_cnt_r == LAST_BIT);

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for a chain of frac_lut4 cells: one word per LUT is
// streamed into the chain head while the displaced word is read back from the tail.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4,
  parameter int WORD_W   = LUT_WORD_W
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int LUT_CNT_W = cnt_width(NUM_LUTS);
  localparam logic [LUT_CNT_W-1:0] LAST_LUT = LUT_CNT_W'(NUM_LUTS - 1);

  lut_state_e           state_r;
  lut_state_e           state_next_s;
  logic [LUT_CNT_W-1:0] lut_cnt_r;
  logic                 cfg_ready_r;
  logic                 shift_en_r;
  logic                 rd_valid_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 load_s;
  logic                 last_bit_s;
  logic                 word_end_s;

  // cfg_ready_r mirrors the LOAD state, so it doubles as the handshake qualifier.
  assign load_s     = cfg_ready_r & cfg_valid & ~abort;
  assign word_end_s = shift_en_r & last_bit_s & ~abort;

  // Next-state decode; abort overrides everything, including a start in IDLE.
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_next_s = ST_LOAD;
          else       state_next_s = ST_IDLE;
        end
        ST_LOAD: begin
          if (cfg_valid) state_next_s = ST_SHIFT;
          else           state_next_s = ST_LOAD;
        end
        ST_SHIFT: begin
          if (last_bit_s) begin
            if (lut_cnt_r == LAST_LUT) state_next_s = ST_DONE;
            else                       state_next_s = ST_LOAD;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end
        ST_DONE: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State, LUT counter and strobes; strobes are decoded from the next state so they align with it.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      lut_cnt_r   <= {LUT_CNT_W{1'b0}};
      cfg_ready_r <= 1'b0;
      shift_en_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cfg_ready_r <= (state_next_s == ST_LOAD);
      shift_en_r  <= (state_next_s == ST_SHIFT);
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= (state_next_s == ST_DONE);
      rd_valid_r  <= word_end_s;
      if ((state_r == ST_IDLE) && start && !abort) begin
        lut_cnt_r <= {LUT_CNT_W{1'b0}};
      end else if (word_end_s) begin
        lut_cnt_r <= lut_cnt_r + LUT_CNT_W'(1'b1);
      end else begin
        lut_cnt_r <= lut_cnt_r;
      end
    end
  end

  lut_cfg_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk       (prog_clk),
    .reset     (reset),
    .load      (load_s),
    .load_data (cfg_data),
    .shift     (shift_en_r),
    .clear     (abort),
    .ser_in    (ccff_tail),
    .ser_out   (ccff_head),
    .par_out   (rd_data),
    .last_bit  (last_bit_s)
  );

  assign cfg_ready = cfg_ready_r;
  assign shift_en  = shift_en_r;
  assign rd_valid  = rd_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench for lut_cfg_loader: directed control table, hand-written
// corner sequences and randomized loads against a word-level chain model.
module tb_lut_cfg_loader;

  localparam int N  = 4;
  localparam int W  = 17;
  localparam int CW = N * W;

  logic          prog_clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_ready, ccff_head, shift_en, ccff_tail, rd_valid, busy, done;
  logic [W-1:0]  rd_data;

  logic [CW-1:0] chain;
  logic [CW-1:0] preload_val = '0;
  logic          preload_req = 1'b0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_fall_cyc = 0, shift_cnt = 0;
  logic busy_q = 1'b0;
  logic [W-1:0] rd_q[$];
  logic [W-1:0] exp_rd[$];
  logic [W-1:0] exp_luts[N];
  logic [W-1:0] ld_words[N];

  typedef struct packed {
    logic         rst;
    logic         st;
    logic         ab;
    logic         vld;
    logic [W-1:0] data;
    logic [5:0]   exp;   // {busy, cfg_ready, shift_en, ccff_head, rd_valid, done}
  } vec_t;
  vec_t vecs[16];

  lut_cfg_loader #(.NUM_LUTS(N), .WORD_W(W)) dut (
    .prog_clk  (prog_clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .ccff_tail (ccff_tail),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural configuration chain: bit 0 is the head, bit CW-1 the tail.
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (preload_req) chain <= preload_val;
    else if (shift_en) chain <= {chain[CW-2:0], ccff_head};
  end
  assign ccff_tail = chain[CW-1];

  always @(negedge prog_clk) begin
    busy_q <= busy;
    if (busy_q && !busy) busy_fall_cyc <= cyc;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (shift_en) shift_cnt <= shift_cnt + 1;
    if (rd_valid) rd_q.push_back(rd_data);
  end

  task automatic tick();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom());
  endfunction

  // Word j of LUT k sits reversed in its slot: bit b at chain position k*W + W-1-b.
  function automatic logic [CW-1:0] luts_to_chain();
    logic [CW-1:0] c = '0;
    for (int k = 0; k < N; k++)
      for (int b = 0; b < W; b++) c[k*W + W-1 - b] = exp_luts[k][b];
    return c;
  endfunction

  function automatic logic [W-1:0] chain_lut(input int k);
    logic [W-1:0] r = '0;
    for (int b = 0; b < W; b++) r[b] = chain[k*W + W-1 - b];
    return r;
  endfunction

  // Loading one word displaces the farthest LUT and pushes everything one LUT deeper.
  task automatic model_load(input logic [W-1:0] w);
    exp_rd.push_back(exp_luts[N-1]);
    for (int k = N-1; k > 0; k--) exp_luts[k] = exp_luts[k-1];
    exp_luts[0] = w;
  endtask

  task automatic preload_chain(input logic [W-1:0] w0, w1, w2, w3);
    exp_luts[0] = w0; exp_luts[1] = w1; exp_luts[2] = w2; exp_luts[3] = w3;
    preload_val = luts_to_chain();
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  task automatic check_chain();
    for (int k = 0; k < N; k++)
      check($sformatf("chain_lut%0d", k), CW'(chain_lut(k)), CW'(exp_luts[k]));
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    bit ok = 1'b0;
    cfg_valid = 1'b0;
    repeat (gap) tick();
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (cfg_ready) ok = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    check("handshake", CW'(ok), CW'(1'b1));
  endtask

  task automatic run_load(input int gap_max, input bit timed);
    int s, db, rb;
    bit ok = 1'b0;
    exp_rd.delete();
    for (int i = 0; i < N; i++) model_load(ld_words[i]);
    db = done_cnt;
    rb = rd_q.size();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++)
      send_word(ld_words[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    for (int t = 0; t < 100 && !ok; t++) begin
      if (done_cnt != db) ok = 1'b1;
      else tick();
    end
    tick();
    tick();
    check("done_seen", CW'(ok), CW'(1'b1));
    check("done_pulses", CW'(done_cnt - db), CW'(1));
    if (timed) begin
      check("done_latency", CW'(done_cyc - (s + 1)), CW'(72));
      check("busy_fall", CW'(busy_fall_cyc - done_cyc), CW'(1));
    end
    check("rd_count", CW'(rd_q.size() - rb), CW'(N));
    for (int i = 0; i < N; i++)
      if (rd_q.size() > rb + i) check($sformatf("rd_word%0d", i), CW'(rd_q[rb+i]), CW'(exp_rd[i]));
    check_chain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] e;
    int sb, db, rb;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h0_0000, 6'b000000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 17'h0_0000, 6'b000000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0000, 6'b000000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h0_0000, 6'b110000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0000, 6'b110000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h0_0000, 6'b110000};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 17'h0_0000, 6'b000000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h0_0000, 6'b110000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 17'h0_0003, 6'b101100};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h0_0003, 6'b101100};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0003, 6'b101000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 17'h0_0000, 6'b000000};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h0_0000, 6'b110000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 17'h1_FFFF, 6'b101100};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h0_0000, 6'b000000};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0000, 6'b000000};

    reset = 1'b1;
    preload_chain('0, '0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab;
      cfg_valid = vecs[i].vld; cfg_data = vecs[i].data;
      tick();
      check($sformatf("vec%0d_ctrl", i), CW'({busy, cfg_ready, shift_en, ccff_head, rd_valid, done}),
            CW'(vecs[i].exp));
      check($sformatf("vec%0d_rd_data", i), CW'(rd_data), '0);
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    tick();

    // Known load with previous contents read back, last LUT first.
    preload_chain(17'h0_1234, 17'h1_5678, 17'h0_9ABC, 17'h1_DEF0);
    ld_words[0] = 17'h1_8000; ld_words[1] = 17'h0_00FF;
    ld_words[2] = 17'h1_AAAA; ld_words[3] = 17'h0_0001;
    run_load(0, 1'b1);

    // cfg_valid withheld in LOAD: the loader must wait without shifting.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_ready", CW'(cfg_ready), CW'(1'b1));
      check("stall_shift", CW'(shift_en), CW'(1'b0));
      tick();
    end
    cfg_data = 17'h0_5555; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("resume_shift", CW'(shift_en), CW'(1'b1));
    abort = 1'b1; tick(); abort = 1'b0;
    check("stall_abort_busy", CW'(busy), CW'(1'b0));

    // Abort partway through the second word.
    preload_chain(rnd_word(), rnd_word(), rnd_word(), rnd_word());
    ld_words[0] = rnd_word(); ld_words[1] = rnd_word();
    exp_rd.delete();
    model_load(ld_words[0]);
    sb = shift_cnt; db = done_cnt; rb = rd_q.size();
    start = 1'b1; tick(); start = 1'b0;
    send_word(ld_words[0], 0);
    send_word(ld_words[1], 0);
    for (int t = 0; t < 100 && (shift_cnt - sb) < 25; t++) tick();
    check("abort_point", CW'(shift_cnt - sb), CW'(25));
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", CW'(busy), CW'(1'b0));
    check("abort_shift", CW'(shift_en), CW'(1'b0));
    repeat (30) tick();
    check("abort_shift_total", CW'(shift_cnt - sb), CW'(25));
    check("abort_no_done", CW'(done_cnt - db), CW'(0));
    check("abort_rd_count", CW'(rd_q.size() - rb), CW'(1));
    if (rd_q.size() > rb) check("abort_rd_word", CW'(rd_q[rb]), CW'(exp_rd[0]));
    e = luts_to_chain();
    for (int j = 0; j < 8; j++) e = {e[CW-2:0], ld_words[1][j]};
    check("abort_chain", chain, e);

    // Reset in the middle of a shift, then a clean load.
    preload_chain(rnd_word(), rnd_word(), rnd_word(), rnd_word());
    start = 1'b1; tick(); start = 1'b0;
    send_word(rnd_word(), 0);
    repeat (5) tick();
    check("pre_reset_shift", CW'(shift_en), CW'(1'b1));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", CW'({cfg_ready, shift_en, ccff_head, rd_valid, busy, done, rd_data}), '0);
    end
    reset = 1'b0;
    tick();
    preload_chain(rnd_word(), rnd_word(), rnd_word(), rnd_word());
    for (int i = 0; i < N; i++) ld_words[i] = rnd_word();
    run_load(0, 1'b1);

    // Randomized loads with random valid gaps.
    for (int it = 0; it < 4; it++) begin
      preload_chain(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      for (int i = 0; i < N; i++) ld_words[i] = rnd_word();
      run_load(3, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
